// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-back, write-allocate cache: 8 lines x 16 bytes, 16-bit CPU port.
// Misses run WRITEBACK (dirty victim only) then ALLOCATE, and then complete as a hit in IDLE.
module direct_mapped_cache (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e       state_q, state_d;
    logic [7:0]   valid_q, valid_d;
    logic [7:0]   dirty_q, dirty_d;
    logic [8:0]   tag_q  [8];
    logic [127:0] data_q [8];

    logic [2:0]   idx;
    logic [8:0]   addr_tag;
    logic [2:0]   word;
    logic         req;
    logic         hit;
    logic         line_we;
    logic [127:0] cur_line;
    logic [127:0] line_d;
    logic [8:0]   tag_d;
    logic         addr_lsb_unused;

    assign idx             = mem_address[6:4];
    assign addr_tag        = mem_address[15:7];
    assign word            = mem_address[3:1];
    assign addr_lsb_unused = mem_address[0];
    assign cur_line        = data_q[idx];
    assign req             = mem_read | mem_write;
    assign hit             = req && valid_q[idx] && (tag_q[idx] == addr_tag);
    assign mem_rdata       = cur_line[{word, 4'b0000} +: 16];

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {mem_address[15:4], 4'b0000};
        pmem_wdata   = cur_line;
        line_we      = 1'b0;
        line_d       = cur_line;
        tag_d        = tag_q[idx];

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    // A write wins over a simultaneous read; empty byte mask still dirties the line.
                    if (mem_write) begin
                        line_we      = 1'b1;
                        dirty_d[idx] = 1'b1;
                        for (int unsigned b = 0; b < 2; b++) begin
                            if (mem_byte_enable[b])
                                line_d[{word, b[0], 3'b000} +: 8] = mem_wdata[8*b +: 8];
                        end
                    end
                end else if (req) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx], idx, 4'b0000};
                if (pmem_resp) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    line_we      = 1'b1;
                    line_d       = pmem_rdata;
                    tag_d        = addr_tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag/data arrays carry no reset; valid gating makes their contents irrelevant until filled.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx] <= line_d;
            tag_q[idx]  <= tag_d;
        end
    end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Self-checking bench for direct_mapped_cache: directed scenarios plus random traffic
// checked against a flat CPU-view memory and a per-index residency model.
module tb_direct_mapped_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // mainmem: backing store contents; ref_mem: what the CPU must observe.
    logic [15:0] mainmem [32768];
    logic [15:0] ref_mem [32768];
    bit          rvalid  [8];
    bit          rdirty  [8];
    logic [8:0]  rtag    [8];
    logic [8:0]  tag_pool [4];

    direct_mapped_cache dut (
        .clk             (clk),
        .reset           (reset),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_line(input logic [11:0] la);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[16*w +: 16] = ref_mem[{la, 3'(w)}];
        return l;
    endfunction

    function automatic logic [127:0] main_line(input logic [11:0] la);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[16*w +: 16] = mainmem[{la, 3'(w)}];
        return l;
    endfunction

    task automatic store_main(input logic [11:0] la, input logic [127:0] l);
        for (int w = 0; w < 8; w++) mainmem[{la, 3'(w)}] = l[16*w +: 16];
    endtask

    // Reset discards every cached line, so dirty data never reached memory.
    task automatic model_reset();
        for (int i = 0; i < 32768; i++) ref_mem[i] = mainmem[i];
        for (int i = 0; i < 8; i++) begin
            rvalid[i] = 1'b0;
            rdirty[i] = 1'b0;
        end
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [1:0] ben, input logic [15:0] wd,
                          input int unsigned lw, input int unsigned lf);
        logic [2:0]  idx;
        logic [8:0]  tg;
        logic [11:0] victim;
        bit          hit, wb, done;
        int unsigned exp_cyc, cnt;
        idx     = addr[6:4];
        tg      = addr[15:7];
        hit     = rvalid[idx] && (rtag[idx] == tg);
        wb      = !hit && rvalid[idx] && rdirty[idx];
        victim  = {rtag[idx], idx};
        exp_cyc = hit ? 0 : ((wb ? lw : 0) + lf + 1);
        cnt     = 0;
        done    = 1'b0;
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = ben;
        mem_wdata       = wd;
        for (int unsigned cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cyc != 0) @(negedge clk);
            pmem_resp = 1'b0;
            #1;
            if (pmem_read && pmem_write) check("pmem_exclusive", {pmem_read, pmem_write}, 2'b00);
            if (cyc == 0 && !mem_resp) check("idle_pmem_quiet", {pmem_read, pmem_write}, 2'b00);
            if (mem_resp) begin
                check("resp_latency", cyc, exp_cyc);
                if (!wr) check("read_data", mem_rdata, ref_mem[addr[15:1]]);
                if (wr) begin
                    if (ben[0]) ref_mem[addr[15:1]][7:0]  = wd[7:0];
                    if (ben[1]) ref_mem[addr[15:1]][15:8] = wd[15:8];
                    rdirty[idx] = 1'b1;
                end
                rvalid[idx] = 1'b1;
                rtag[idx]   = tg;
                done        = 1'b1;
            end else if (pmem_write) begin
                if (cnt == 0) begin
                    check("wb_expected", pmem_write, wb);
                    check("wb_addr", pmem_address, {victim, 4'b0000});
                    check("wb_data", pmem_wdata, ref_line(victim));
                end
                cnt++;
                if (cnt >= lw) begin
                    store_main(victim, pmem_wdata);
                    rdirty[idx] = 1'b0;
                    pmem_resp   = 1'b1;
                    cnt         = 0;
                end
            end else if (pmem_read) begin
                if (cnt == 0) begin
                    check("fill_expected", pmem_read, !hit);
                    check("fill_addr", pmem_address, {addr[15:4], 4'b0000});
                end
                cnt++;
                if (cnt >= lf) begin
                    pmem_rdata = main_line(addr[15:4]);
                    pmem_resp  = 1'b1;
                    cnt        = 0;
                end
            end
        end
        if (!done) check("resp_timeout", done, 1'b1);
    endtask

    task automatic idle_cycle(input bit stale);
        @(negedge clk);
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        pmem_resp  = stale;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check("idle_resp", mem_resp, 1'b0);
        check("idle_pmem", {pmem_read, pmem_write}, 2'b00);
    endtask

    task automatic reset_mid_fill(input logic [15:0] a);
        int unsigned seen;
        seen = 0;
        @(negedge clk);
        pmem_resp   = 1'b0;
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        mem_address = a;
        for (int unsigned c = 0; c < 8 && seen < 2; c++) begin
            @(negedge clk);
            #1;
            if (pmem_read) seen++;
        end
        check("midfill_reached", seen, 2);
        reset = 1'b1;
        #1;
        check("midfill_read_drop", pmem_read, 1'b0);
        check("midfill_write_low", pmem_write, 1'b0);
        check("midfill_resp_low", mem_resp, 1'b0);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        pmem_rdata = {8{16'hDEAD}};
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        check("stale_resp_ignored", {mem_resp, pmem_read, pmem_write}, 3'b000);
        do_req(1'b1, 1'b0, a, 2'b00, 16'h0000, 1, 2);
    endtask

    initial begin
        logic [15:0] a;
        logic        rd, wr;
        tag_pool[0] = 9'h024;
        tag_pool[1] = 9'h025;
        tag_pool[2] = 9'h1A3;
        tag_pool[3] = 9'h0FF;
        for (int i = 0; i < 32768; i++) mainmem[i] = 16'(i * 40503) ^ 16'h5A5A;
        mainmem[16'h1232 >> 1] = 16'hBEEF;
        mainmem[16'h1234 >> 1] = 16'hBEEF;
        model_reset();

        reset           = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        pmem_rdata      = '0;
        pmem_resp       = 1'b0;
        #1;
        check("reset_outputs", {mem_resp, pmem_read, pmem_write}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Cold miss, fill after 3 cycles, then hits on the filled line.
        do_req(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, 1, 3);
        do_req(1'b1, 1'b0, 16'h1232, 2'b00, 16'h0000, 1, 1);
        // Low-byte write hit, readback, then dirty eviction at the same index.
        do_req(1'b0, 1'b1, 16'h1232, 2'b01, 16'h00AA, 1, 1);
        do_req(1'b1, 1'b0, 16'h1232, 2'b00, 16'h0000, 1, 1);
        check("byte_merge_value", mem_rdata, 16'hBEAA);
        do_req(1'b1, 1'b0, 16'h12B0, 2'b00, 16'h0000, 2, 2);
        // Clean eviction back to the original tag.
        do_req(1'b1, 1'b0, 16'h1230, 2'b00, 16'h0000, 3, 2);
        // Back-to-back hits, including a read+write treated as a write and an empty-mask write.
        do_req(1'b1, 1'b0, 16'h1230, 2'b00, 16'h0000, 1, 1);
        do_req(1'b0, 1'b1, 16'h1234, 2'b11, 16'hC0DE, 1, 1);
        do_req(1'b1, 1'b1, 16'h1236, 2'b10, 16'h7700, 1, 1);
        do_req(1'b0, 1'b1, 16'h1238, 2'b00, 16'hFFFF, 1, 1);
        idle_cycle(1'b1);
        do_req(1'b1, 1'b0, 16'h12B4, 2'b00, 16'h0000, 1, 4);
        idle_cycle(1'b0);

        reset_mid_fill(16'h5550);

        for (int n = 0; n < 300; n++) begin
            wr = $urandom_range(0, 1) == 1;
            rd = !wr || ($urandom_range(0, 3) == 0);
            a  = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            do_req(rd, wr, a, 2'($urandom_range(0, 3)), 16'($urandom),
                   $urandom_range(1, 4), $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
